// File: rtl/rx_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rx_buffer_ctrl
// Purpose  : Two-entry UART receive buffer (UDR FIFO) with error flags,
//            character-size masking and receive-complete interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module rx_buffer_ctrl (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxen,
  input  logic [2:0] i_ucsz,
  input  logic [8:0] i_shift_register,
  input  logic       i_shift_register_valid,
  input  logic       i_frame_error,
  input  logic       i_parity_error,
  input  logic       i_data_overrun,
  input  logic       i_udr_read,
  input  logic       i_rxcie,
  output logic [7:0] o_udr,
  output logic       o_rxb8,
  output logic       o_fe,
  output logic       o_upe,
  output logic       o_dor,
  output logic       o_rxc,
  output logic       o_rxc_int,
  output logic       o_udr_valid,
  output logic       o_receive_buffer_valid
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Entry layout: [11:3] data, [2] FE, [1] UPE, [0] DOR
  localparam logic [11:0] c_ENTRY_ZERO = 12'h000;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_ent0;
  logic [11:0] r_ent1;
  logic [11:0] w_ent0_nxt;
  logic [11:0] w_ent1_nxt;
  logic [11:0] w_new;
  logic        w_wr;
  logic        w_rd;

  assign w_new = {i_shift_register, i_frame_error, i_parity_error, i_data_overrun};
  assign w_wr  = i_shift_register_valid;
  assign w_rd  = i_udr_read && (r_state != ST_EMPTY);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_EMPTY;
      r_ent0  <= c_ENTRY_ZERO;
      r_ent1  <= c_ENTRY_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_ent0  <= w_ent0_nxt;
      r_ent1  <= w_ent1_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ent0_nxt  = r_ent0;
    w_ent1_nxt  = r_ent1;
    if (!i_rxen) begin
      // Flush wins over any coincident write or read
      w_state_nxt = ST_EMPTY;
      w_ent0_nxt  = c_ENTRY_ZERO;
      w_ent1_nxt  = c_ENTRY_ZERO;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_wr) begin
            w_ent0_nxt  = w_new;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_wr && w_rd) begin
            w_ent0_nxt = w_new;
            w_ent1_nxt = c_ENTRY_ZERO;
          end else if (w_wr) begin
            w_ent1_nxt  = w_new;
            w_state_nxt = ST_FULL;
          end else if (w_rd) begin
            w_ent0_nxt  = r_ent1;
            w_ent1_nxt  = c_ENTRY_ZERO;
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_wr && w_rd) begin
            w_ent0_nxt = r_ent1;
            w_ent1_nxt = w_new;
          end else if (w_wr) begin
            // Overrun: frame dropped, tail carries a sticky DOR
            w_ent1_nxt[0] = 1'b1;
          end else if (w_rd) begin
            w_ent0_nxt  = r_ent1;
            w_ent1_nxt  = c_ENTRY_ZERO;
            w_state_nxt = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_ent0_nxt  = c_ENTRY_ZERO;
          w_ent1_nxt  = c_ENTRY_ZERO;
        end
      endcase
    end
  end

  logic       w_head_valid;
  logic       w_ucsz_ok;
  logic [8:0] w_head_data;
  logic [7:0] w_udr_masked;

  assign w_head_valid = (r_state != ST_EMPTY);
  assign w_head_data  = r_ent0[11:3];
  assign w_ucsz_ok    = (i_ucsz[2] == 1'b0) || (i_ucsz == 3'b111);

  always_comb begin
    w_udr_masked = 8'h00;
    case (i_ucsz)
      3'b000:  w_udr_masked = {3'b000, w_head_data[4:0]};
      3'b001:  w_udr_masked = {2'b00, w_head_data[5:0]};
      3'b010:  w_udr_masked = {1'b0, w_head_data[6:0]};
      3'b011,
      3'b111:  w_udr_masked = w_head_data[7:0];
      default: w_udr_masked = 8'h00;
    endcase
  end

  assign o_udr                  = (w_head_valid && w_ucsz_ok) ? w_udr_masked : 8'h00;
  assign o_rxb8                 = w_head_valid && (i_ucsz == 3'b111) && w_head_data[8];
  assign o_fe                   = w_head_valid && w_ucsz_ok && r_ent0[2];
  assign o_upe                  = w_head_valid && w_ucsz_ok && r_ent0[1];
  assign o_dor                  = w_head_valid && w_ucsz_ok && r_ent0[0];
  assign o_rxc                  = w_head_valid;
  assign o_udr_valid            = w_head_valid;
  assign o_rxc_int              = w_head_valid && i_rxcie;
  assign o_receive_buffer_valid = (r_state == ST_FULL);

endmodule
`default_nettype wire

// File: tb/tb_rx_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_buffer_ctrl
// Purpose  : Self-checking bench: queue-based reference model compared every
//            cycle, plus directed literal checks of the documented scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_buffer_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_rxen = 1'b1;
  logic [2:0] i_ucsz = 3'b011;
  logic [8:0] i_shift_register = 9'h000;
  logic       i_shift_register_valid = 1'b0;
  logic       i_frame_error = 1'b0;
  logic       i_parity_error = 1'b0;
  logic       i_data_overrun = 1'b0;
  logic       i_udr_read = 1'b0;
  logic       i_rxcie = 1'b0;
  logic [7:0] o_udr;
  logic       o_rxb8, o_fe, o_upe, o_dor, o_rxc, o_rxc_int;
  logic       o_udr_valid, o_receive_buffer_valid;

  int n_cmp = 0;
  int n_bad = 0;

  rx_buffer_ctrl dut (
    .i_clk                  (i_clk),
    .i_rst_n                (i_rst_n),
    .i_rxen                 (i_rxen),
    .i_ucsz                 (i_ucsz),
    .i_shift_register       (i_shift_register),
    .i_shift_register_valid (i_shift_register_valid),
    .i_frame_error          (i_frame_error),
    .i_parity_error         (i_parity_error),
    .i_data_overrun         (i_data_overrun),
    .i_udr_read             (i_udr_read),
    .i_rxcie                (i_rxcie),
    .o_udr                  (o_udr),
    .o_rxb8                 (o_rxb8),
    .o_fe                   (o_fe),
    .o_upe                  (o_upe),
    .o_dor                  (o_dor),
    .o_rxc                  (o_rxc),
    .o_rxc_int              (o_rxc_int),
    .o_udr_valid            (o_udr_valid),
    .o_receive_buffer_valid (o_receive_buffer_valid)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: list of frames {data[8:0], fe, upe, dor}, head first
  logic [11:0] q[$];

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q.delete();
    end else if (!i_rxen) begin
      q.delete();
    end else begin
      logic        rd;
      logic [11:0] nw;
      nw = {i_shift_register, i_frame_error, i_parity_error, i_data_overrun};
      rd = i_udr_read && (q.size() > 0);
      if (rd) void'(q.pop_front());
      if (i_shift_register_valid) begin
        if (q.size() < 2) q.push_back(nw);
        else q[1][0] = 1'b1;
      end
    end
  end

  function automatic logic [14:0] model_out();
    logic [7:0] udr;
    logic [8:0] d;
    logic       rb8, fe, upe, dor, nonempty, reserved;
    int         nbits;
    nonempty = (q.size() > 0);
    reserved = (i_ucsz >= 3'd4) && (i_ucsz != 3'd7);
    udr = 8'h00; rb8 = 1'b0; fe = 1'b0; upe = 1'b0; dor = 1'b0;
    if (nonempty && !reserved) begin
      d     = q[0][11:3];
      nbits = (i_ucsz == 3'd7) ? 8 : 5 + int'(i_ucsz);
      udr   = 8'(int'(d[7:0]) % (1 << nbits));
      rb8   = (i_ucsz == 3'd7) ? d[8] : 1'b0;
      fe    = q[0][2];
      upe   = q[0][1];
      dor   = q[0][0];
    end
    return {udr, rb8, fe, upe, dor, nonempty, nonempty && i_rxcie,
            nonempty, q.size() == 2};
  endfunction

  // Every-cycle comparison, on the inactive edge
  always @(negedge i_clk) begin
    logic [14:0] act, expv;
    act  = {o_udr, o_rxb8, o_fe, o_upe, o_dor, o_rxc, o_rxc_int,
            o_udr_valid, o_receive_buffer_valid};
    expv = model_out();
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act, expv);
    end
  end

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // Drive one cycle of stimulus; outputs are stable 2 time units after the edge
  task automatic step(input logic wv, input logic [8:0] d, input logic [2:0] err,
                      input logic rd);
    i_shift_register_valid = wv;
    i_shift_register       = d;
    {i_frame_error, i_parity_error, i_data_overrun} = err;
    i_udr_read             = rd;
    @(posedge i_clk); #2;
    i_shift_register_valid = 1'b0;
    i_udr_read             = 1'b0;
    {i_frame_error, i_parity_error, i_data_overrun} = 3'b000;
  endtask

  task automatic wr(input logic [8:0] d);
    step(1'b1, d, 3'b000, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 9'h000, 3'b000, 1'b1);
  endtask

  function automatic logic [8:0] all_out();
    return {o_udr == 8'h00 ? 1'b0 : 1'b1, o_rxb8, o_fe, o_upe, o_dor, o_rxc,
            o_rxc_int, o_udr_valid, o_receive_buffer_valid};
  endfunction

  initial begin
    repeat (2) @(posedge i_clk);
    #2;
    chk("reset_outputs", all_out(), 9'h000);
    i_rst_n = 1'b1;
    @(posedge i_clk); #2;

    // Basic write then read
    wr(9'h0A5);
    chk("basic_udr", {1'b0, o_udr}, 9'h0A5);
    chk("basic_rxc_valid", {7'd0, o_rxc, o_udr_valid}, 9'h003);
    rd();
    chk("basic_after_read_rxc", {8'd0, o_rxc}, 9'h000);

    // Overrun while full
    wr(9'h011); wr(9'h022); wr(9'h033);
    chk("ovr_full", {8'd0, o_receive_buffer_valid}, 9'h001);
    chk("ovr_head1", {o_dor, o_udr}, 9'h011);
    rd();
    chk("ovr_head2_dor", {o_dor, o_udr}, 9'h122);
    rd();
    chk("ovr_empty", {7'd0, o_rxc, o_receive_buffer_valid}, 9'h000);

    // Simultaneous write+read while full
    wr(9'h011); wr(9'h022);
    step(1'b1, 9'h044, 3'b000, 1'b1);
    chk("wr_rd_full_head", {o_receive_buffer_valid, o_udr}, 9'h122);
    rd();
    chk("wr_rd_full_next", {o_receive_buffer_valid, o_udr}, 9'h044);
    rd();

    // Simultaneous write+read with one entry
    wr(9'h011);
    step(1'b1, 9'h066, 3'b000, 1'b1);
    chk("wr_rd_one_head", {o_receive_buffer_valid, o_udr}, 9'h066);
    rd();

    // Character size masking
    i_ucsz = 3'b000;
    step(1'b1, 9'h1FF, 3'b100, 1'b0);
    chk("ucsz5_udr", {1'b0, o_udr}, 9'h01F);
    chk("ucsz5_rxb8_fe", {7'd0, o_rxb8, o_fe}, 9'h001);
    rd();
    i_ucsz = 3'b111;
    wr(9'h1FF);
    chk("ucsz9_udr_rxb8", {o_rxb8, o_udr}, 9'h1FF);
    i_ucsz = 3'b101;
    #1;
    chk("reserved_udr", {o_rxb8, o_udr}, 9'h000);
    chk("reserved_rxc", {8'd0, o_rxc}, 9'h001);
    i_ucsz = 3'b011;
    rd();

    // Read when empty, then flush from full (flush beats coincident write)
    rd();
    chk("empty_read", all_out(), 9'h000);
    wr(9'h011); wr(9'h022);
    i_rxen = 1'b0;
    step(1'b1, 9'h077, 3'b000, 1'b0);
    chk("flush", {7'd0, o_rxc, o_receive_buffer_valid}, 9'h000);
    i_rxen = 1'b1;
    @(posedge i_clk); #2;

    // Interrupt, then async reset while full
    i_rxcie = 1'b1;
    wr(9'h055);
    chk("rxc_int", {8'd0, o_rxc_int}, 9'h001);
    wr(9'h056);
    #1 i_rst_n = 1'b0;
    #1;
    chk("async_reset", all_out(), 9'h000);
    @(posedge i_clk); #2;
    i_rst_n = 1'b1;
    @(posedge i_clk); #2;
    chk("after_reset_empty", all_out(), 9'h000);

    // Pseudo-random traffic checked by the model
    for (int i = 0; i < 300; i++) begin
      i_ucsz  = ($urandom_range(0, 7) == 0) ? 3'b101 : 3'($urandom_range(0, 7));
      i_rxen  = ($urandom_range(0, 19) != 0);
      i_rxcie = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 9'($urandom), 3'($urandom),
           1'($urandom_range(0, 2) == 0));
    end

    @(posedge i_clk); #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
